// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, requester ids and
// default widths / watchdog limit.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int DATA_W_DEF  = 64;
  localparam int TIMEOUT_DEF = 255;
  localparam int WDOG_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } src_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-requester round-robin picker: on a tie the source that did not win last
// time is chosen; a lone requester always wins.
import mem_arbiter_pkg::*;

module rr_pick2 (
  input  logic req_data,
  input  logic req_fetch,
  input  src_t last_gnt,
  output logic valid,
  output src_t winner
);

  always_comb begin
    valid  = req_data | req_fetch;
    winner = SRC_FETCH;
    if (req_data && req_fetch) begin
      winner = (last_gnt == SRC_FETCH) ? SRC_DATA : SRC_FETCH;
    end else if (req_data) begin
      winner = SRC_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data load/store requests onto a single
// command/response bus, one transaction at a time, with a response watchdog.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_rd_en,
  input  logic [ADDR_W-1:0]   d_rd_addr,
  input  logic                d_wr_en,
  input  logic [ADDR_W-1:0]   d_wr_addr,
  input  logic [DATA_W-1:0]   d_wr_data,
  input  logic [DATA_W/8-1:0] d_wr_strb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_strb,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  src_t                owner_q, last_gnt_q, winner;
  logic                pick_valid;
  logic [WDOG_W-1:0]   wdog_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                if_ack_q, d_ack_q, err_q;
  logic                resp_hit, timeout_hit;

  rr_pick2 u_pick (
    .req_data (d_rd_en | d_wr_en),
    .req_fetch(if_req),
    .last_gnt (last_gnt_q),
    .valid    (pick_valid),
    .winner   (winner)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    resp_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_REQ;
      // rvalid is not looked at here: grant plus rvalid in REQ is a grant only.
      ST_REQ:  if (bus_gnt) state_d = ST_WAIT;
      ST_WAIT: begin
        resp_hit    = bus_rvalid;
        timeout_hit = !bus_rvalid && (wdog_q == WDOG_LAST);
        if (resp_hit || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= SRC_FETCH;
      last_gnt_q <= SRC_FETCH;
      wdog_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: if (pick_valid) begin
          owner_q    <= winner;
          last_gnt_q <= winner;
          // A pending store goes ahead of a pending load from the same port.
          if (winner == SRC_FETCH) begin
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
            strb_q  <= '0;
          end else if (d_wr_en) begin
            we_q    <= 1'b1;
            addr_q  <= d_wr_addr;
            wdata_q <= d_wr_data;
            strb_q  <= d_wr_strb;
          end else begin
            we_q    <= 1'b0;
            addr_q  <= d_rd_addr;
            wdata_q <= '0;
            strb_q  <= '0;
          end
        end
        ST_REQ: if (bus_gnt) wdog_q <= '0;
        ST_WAIT: begin
          wdog_q <= wdog_q + WDOG_W'(1);
          if (resp_hit || timeout_hit) begin
            rdata_q  <= resp_hit ? bus_rdata : '0;
            if_ack_q <= (owner_q == SRC_FETCH);
            d_ack_q  <= (owner_q == SRC_DATA);
            err_q    <= timeout_hit;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req   = (state_q == ST_REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_strb  = strb_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = err_q;
  assign stall     = (if_req | d_rd_en | d_wr_en) & ~(if_ack_q | d_ack_q);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDR_W, 64, memory address width.
- DATA_W, 64, memory data width; strobe width is DATA_W/8.
- TIMEOUT, 255, maximum WAIT cycles before forced completion.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  the single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  instruction fetch read request, level, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data, valid with if_ack.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_rd_en  in  1  data load request, level, held until d_ack.
- d_rd_addr  in  ADDR_W  load address.
- d_wr_en  in  1  data store request, level, held until d_ack.
- d_wr_addr  in  ADDR_W  store address.
- d_wr_data  in  DATA_W  store data.
- d_wr_strb  in  DATA_W/8  store byte strobes.
- d_rdata  out  DATA_W  load data, valid with d_ack.
- d_ack  out  1  one-cycle data completion pulse.
- stall  out  1  pipeline hold.
- bus_req  out  1  bus command valid.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  command address.
- bus_wdata  out  DATA_W  write data.
- bus_strb  out  DATA_W/8  write strobes; all-zero on reads.
- bus_gnt  in  1  command accepted when bus_gnt and bus_req are both high.
- bus_rvalid  in  1  response valid; one pulse per accepted command, writes included.
- bus_rdata  in  DATA_W  read response data.
- bus_err  out  1  one-cycle timeout indication.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT and RESP.
- IDLE -> REQ on any pending request; the winner's fields are latched.
- REQ -> WAIT on bus_gnt.
- WAIT -> RESP on bus_rvalid or timeout.
- RESP -> IDLE unconditionally.
REQ-004 The block SHALL sample new requests only in IDLE; a request still held high during RESP is not re-accepted in that cycle.
REQ-005 Arbitration SHALL be round-robin between the data and fetch sources using a last-grant bit; the last-grant bit resets to fetch, so data wins the first tie.
REQ-006 When d_wr_en and d_rd_en are both high, the block SHALL service the store first and the load in a later transaction.
REQ-007 The block SHALL drive bus_req high only in REQ, with bus_we, bus_addr, bus_wdata and bus_strb stable from latched values until the grant.
REQ-008 In RESP the block SHALL drive the owner's ack high for exactly one cycle, with registered rdata (bus_rdata captured at bus_rvalid); the other ack SHALL stay 0.
REQ-009 Store completion SHALL pulse d_ack, and d_rdata is don't-care for stores.
REQ-010 A 16-bit watchdog SHALL clear on entry to WAIT and increment each WAIT cycle.
- When the count reaches TIMEOUT, the FSM SHALL go to RESP.
- rdata SHALL be forced to 0 and bus_err SHALL pulse together with the ack.
REQ-011 bus_rvalid arriving in any state other than WAIT SHALL be ignored.
REQ-012 bus_gnt and bus_rvalid asserted in the same cycle while in REQ SHALL be treated as grant only; the response is expected in a later cycle.
REQ-013 stall SHALL equal (if_req | d_rd_en | d_wr_en) & ~(if_ack | d_ack) and is combinational.
REQ-014 Minimum latency SHALL be: request in IDLE at cycle 0, REQ at cycle 1, WAIT at cycle 2 with same-cycle grant, RESP/ack at cycle 3 with rvalid at cycle 2.

Reset
REQ-015 While rst_n = 0 at a clock edge, the following SHALL reset:
- FSM to IDLE;
- bus_req, bus_we, if_ack, d_ack and bus_err to 0;
- all data, address and strobe outputs and latches to 0;
- watchdog to 0 and last-grant to fetch.
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction without issuing an ack; a later stray bus_rvalid SHALL be ignored per REQ-011.

Structure
REQ-017 FSM state encodings and TIMEOUT default SHALL live in the shared define file alongside the existing bus-width and strobe constants.
REQ-018 The block SHALL be a single module with no sub-modules; a two-requester round-robin picker MAY be split out as rr_pick2.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Fetch only, addr 0x80000000, gnt at cycle 1, rvalid at cycle 2, rdata 0x13 -> if_ack at cycle 3 with if_rdata 0x13, stall low at cycle 3.
- d_rd_en and if_req together from reset -> data served first, fetch next; exactly one ack per request.
- d_wr_en and d_rd_en together, strb 0x0F, data 0xDEADBEEF -> bus_we=1, bus_strb 0x0F first, then read with bus_strb 0x00.
- Grant withheld 10 cycles -> bus_req and bus_addr stable throughout, no ack.
- No rvalid for TIMEOUT cycles -> ack with rdata 0 and bus_err one pulse, FSM back to IDLE.
- rst_n low during WAIT, then stray rvalid -> no ack, outputs 0, next request served normally.
